// File: rtl/riscv_pkg.sv
// Shared core constants: register-file geometry, default scoreboard depth
// and the base RV32I major opcodes.
package riscv_pkg;

    localparam int XLEN            = 32;
    localparam int NREG            = 32;
    localparam int MAXPEND_DEFAULT = 3;

    typedef enum logic [6:0] {
        OP     = 7'b0110011,
        OP_IMM = 7'b0010011,
        LOAD   = 7'b0000011,
        STORE  = 7'b0100011,
        BRANCH = 7'b1100011,
        JAL    = 7'b1101111,
        JALR   = 7'b1100111
    } opcode_e;

endpackage

// File: rtl/sb_cnt.sv
// Per-register pending-write counter: one increment and two independent
// decrements per cycle, clamped at zero (flagging underflow) and at MAXPEND.
module sb_cnt #(
    parameter  int MAXPEND = 3,
    localparam int CW      = $clog2(MAXPEND + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc_i,
    input  logic          dec_wb_i,
    input  logic          dec_kill_i,
    output logic [CW-1:0] cnt_o,
    output logic          uflow_o
);

    localparam int SW = CW + 2;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] up, down, diff;

    always_comb begin
        up      = {2'b00, cnt_q} + SW'(inc_i);
        down    = SW'(dec_wb_i) + SW'(dec_kill_i);
        diff    = up - down;
        uflow_o = 1'b0;
        cnt_d   = cnt_q;
        if (up < down) begin
            cnt_d   = '0;
            uflow_o = 1'b1;
        end else if (diff > SW'(MAXPEND)) begin
            cnt_d = CW'(MAXPEND);
        end else begin
            cnt_d = diff[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with integrated write scoreboard: combinational read ports
// with writeback bypass, per-register pending-write counts and a sticky error.
module regfile_sb #(
    parameter  int XLEN    = riscv_pkg::XLEN,
    parameter  int NREG    = riscv_pkg::NREG,
    parameter  int NRD     = 2,
    parameter  int MAXPEND = riscv_pkg::MAXPEND_DEFAULT,
    localparam int AW      = $clog2(NREG),
    localparam int CW      = $clog2(MAXPEND + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]    rs_busy,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic              issue_ready,
    input  logic              kill_valid,
    input  logic [AW-1:0]     kill_rd,
    input  logic              wb_valid,
    input  logic [AW-1:0]     wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              sb_err
);

    localparam logic [AW:0]   NREG_W  = (AW + 1)'(NREG);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAXPEND);

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NREG_W;
    endfunction

    logic [XLEN-1:0] data_q [NREG];
    logic [XLEN-1:0] data_d [NREG];
    logic [CW-1:0]   pend   [NREG];
    logic [NREG-1:0] uflow;
    logic            sb_err_q, sb_err_d;
    logic            issue_ok;
    logic [CW-1:0]   issue_pend;

    // x0 has no counter: it is never busy and never underflows
    assign pend[0]  = '0;
    assign uflow[0] = 1'b0;

    always_comb begin
        issue_ok    = in_range(issue_rd) && (issue_rd != '0);
        issue_pend  = issue_ok ? pend[issue_rd] : '0;
        issue_ready = !(issue_ok && (issue_pend == CNT_MAX)
                        && !(wb_valid && (wb_rd == issue_rd))
                        && !(kill_valid && (kill_rd == issue_rd)));
    end

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        logic inc, dec_wb, dec_kill;
        assign inc      = issue_valid && issue_ready && (issue_rd == AW'(r));
        assign dec_wb   = wb_valid && (wb_rd == AW'(r));
        assign dec_kill = kill_valid && (kill_rd == AW'(r));

        sb_cnt #(.MAXPEND(MAXPEND)) u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc_i     (inc),
            .dec_wb_i  (dec_wb),
            .dec_kill_i(dec_kill),
            .cnt_o     (pend[r]),
            .uflow_o   (uflow[r])
        );
    end

    always_comb begin
        data_d = data_q;
        if (wb_valid && (wb_rd != '0) && in_range(wb_rd)) data_d[wb_rd] = wb_data;
        sb_err_d = sb_err_q | (|uflow)
                 | (issue_valid && !in_range(issue_rd))
                 | (kill_valid  && !in_range(kill_rd))
                 | (wb_valid    && !in_range(wb_rd));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '{default: '0};
            sb_err_q <= 1'b0;
        end else begin
            data_q   <= data_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

    // A single outstanding write being retired this cycle is not a hazard
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit, byp;
        logic [CW-1:0] p;
        assign addr = rs_addr[k*AW +: AW];
        assign hit  = in_range(addr) && (addr != '0);
        assign byp  = hit && wb_valid && (wb_rd == addr);
        assign p    = hit ? pend[addr] : '0;
        assign rs_data[k*XLEN +: XLEN] = byp ? wb_data : (hit ? data_q[addr] : '0);
        assign rs_busy[k] = (p != '0) && !(byp && (p == CW'(1)));
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised plus directed bench for regfile_sb against an integer
// reference model of register contents, pending counts and the error flag.
module tb_regfile_sb;

    localparam int XLEN = 32, NREG = 32, NRD = 2, MAXPEND = 3, AW = 5;

    logic              clk = 1'b0, rst_n = 1'b0;
    logic [NRD*AW-1:0] rs_addr = '0;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]    rs_busy;
    logic              issue_valid = 1'b0, kill_valid = 1'b0, wb_valid = 1'b0;
    logic [AW-1:0]     issue_rd = '0, kill_rd = '0, wb_rd = '0;
    logic [XLEN-1:0]   wb_data = '0;
    logic              issue_ready, sb_err;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .MAXPEND(MAXPEND)) dut (
        .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .kill_valid(kill_valid), .kill_rd(kill_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    logic [XLEN-1:0] m_data [NREG];
    int              m_pend [NREG];
    bit              m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_data[i] = '0;
            m_pend[i] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic drive(input bit iv, input int ird, input bit kv, input int krd,
                         input bit wv, input int wrd, input logic [XLEN-1:0] wd,
                         input int a0, input int a1);
        issue_valid = iv; issue_rd = AW'(ird);
        kill_valid  = kv; kill_rd  = AW'(krd);
        wb_valid    = wv; wb_rd    = AW'(wrd); wb_data = wd;
        rs_addr     = {AW'(a1), AW'(a0)};
    endtask

    function automatic bit model_ready();
        int r = int'(issue_rd);
        if (r == 0 || m_pend[r] < MAXPEND) return 1'b1;
        if (wb_valid && int'(wb_rd) == r) return 1'b1;
        if (kill_valid && int'(kill_rd) == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_model();
        logic [NRD-1:0] exp_busy;
        for (int k = 0; k < NRD; k++) begin
            int a = int'(rs_addr[k*AW +: AW]);
            bit byp = wb_valid && int'(wb_rd) == a && a != 0;
            logic [XLEN-1:0] exp_d = (a == 0) ? '0 : (byp ? wb_data : m_data[a]);
            exp_busy[k] = (a != 0) && (m_pend[a] > 0) && !(m_pend[a] == 1 && byp);
            chk($sformatf("rd%0d_data", k), 64'(rs_data[k*XLEN +: XLEN]), 64'(exp_d));
        end
        chk("rs_busy", 64'(rs_busy), 64'(exp_busy));
        chk("issue_ready", 64'(issue_ready), 64'(model_ready()));
        chk("sb_err", 64'(sb_err), 64'(m_err));
    endtask

    task automatic update_model();
        bit rdy = model_ready();
        for (int r = 1; r < NREG; r++) begin
            int n = m_pend[r];
            if (issue_valid && rdy && int'(issue_rd) == r) n++;
            if (wb_valid && int'(wb_rd) == r) n--;
            if (kill_valid && int'(kill_rd) == r) n--;
            if (n < 0) begin
                n = 0;
                m_err = 1'b1;
            end
            m_pend[r] = n;
        end
        if (wb_valid && wb_rd != '0) m_data[int'(wb_rd)] = wb_data;
    endtask

    task automatic finish_step();
        check_model();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        finish_step();
    endtask

    function automatic int rand_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NREG - 1))
                                           : int'($urandom_range(0, 6));
    endfunction

    initial begin
        model_reset();
        #23 rst_n = 1'b1;
        @(posedge clk); #1;

        // idle after reset
        drive(0, 0, 0, 0, 0, 0, '0, 5, 0);
        @(negedge clk);
        chk("rst_data0", 64'(rs_data[XLEN-1:0]), 64'h0);
        chk("rst_data1", 64'(rs_data[2*XLEN-1:XLEN]), 64'h0);
        chk("rst_busy", 64'(rs_busy), 64'h0);
        chk("rst_ready", 64'(issue_ready), 64'h1);
        chk("rst_err", 64'(sb_err), 64'h0);
        finish_step();

        // issue x5, read busy, bypassed writeback clears busy
        drive(1, 5, 0, 0, 0, 0, '0, 5, 0); step();
        drive(0, 0, 0, 0, 0, 0, '0, 5, 0);
        @(negedge clk); chk("x5_busy", 64'(rs_busy), 64'h1); finish_step();
        drive(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
        @(negedge clk);
        chk("x5_byp_data", 64'(rs_data[XLEN-1:0]), 64'hDEADBEEF);
        chk("x5_byp_busy", 64'(rs_busy), 64'h0);
        finish_step();
        drive(0, 0, 0, 0, 0, 0, '0, 5, 0);
        @(negedge clk); chk("x5_after_busy", 64'(rs_busy), 64'h0); finish_step();

        // saturate x7 at MAXPEND
        for (int i = 0; i < 3; i++) begin
            drive(1, 7, 0, 0, 0, 0, '0, 7, 0); step();
        end
        drive(1, 7, 0, 0, 0, 0, '0, 7, 0);
        @(negedge clk); chk("x7_full_ready", 64'(issue_ready), 64'h0); finish_step();
        drive(1, 7, 0, 0, 1, 7, 32'h1, 7, 0);
        @(negedge clk); chk("x7_wb_ready", 64'(issue_ready), 64'h1); finish_step();
        drive(1, 7, 0, 0, 0, 0, '0, 7, 0);
        @(negedge clk); chk("x7_still_full", 64'(issue_ready), 64'h0); finish_step();

        // kill one of two pending writes to x9
        drive(1, 9, 0, 0, 0, 0, '0, 9, 0); step();
        drive(1, 9, 0, 0, 0, 0, '0, 9, 0); step();
        drive(0, 0, 1, 9, 0, 0, '0, 9, 0); step();
        drive(0, 0, 0, 0, 0, 0, '0, 9, 0);
        @(negedge clk); chk("x9_killed_busy", 64'(rs_busy), 64'h1); finish_step();
        drive(0, 0, 0, 0, 1, 9, 32'h12, 9, 0);
        @(negedge clk);
        chk("x9_wb_busy", 64'(rs_busy), 64'h0);
        chk("x9_wb_data", 64'(rs_data[XLEN-1:0]), 64'h12);
        finish_step();

        // writeback with nothing pending, then wb+kill at count 2
        drive(0, 0, 0, 0, 1, 3, 32'h33, 3, 0); step();
        drive(0, 0, 0, 0, 0, 0, '0, 3, 0);
        @(negedge clk);
        chk("x3_err", 64'(sb_err), 64'h1);
        chk("x3_data", 64'(rs_data[XLEN-1:0]), 64'h33);
        finish_step();
        drive(1, 4, 0, 0, 0, 0, '0, 4, 0); step();
        drive(1, 4, 0, 0, 0, 0, '0, 4, 0); step();
        drive(0, 0, 1, 4, 1, 4, 32'h44, 4, 0); step();
        drive(0, 0, 0, 0, 0, 0, '0, 4, 0);
        @(negedge clk);
        chk("x4_busy", 64'(rs_busy), 64'h0);
        chk("err_sticky", 64'(sb_err), 64'h1);
        finish_step();

        // asynchronous reset between edges with x7 still pending
        drive(0, 0, 0, 0, 0, 0, '0, 7, 5);
        #1;
        chk("pre_rst_busy", 64'(rs_busy), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("async_busy", 64'(rs_busy), 64'h0);
        chk("async_data0", 64'(rs_data[XLEN-1:0]), 64'h0);
        chk("async_data1", 64'(rs_data[2*XLEN-1:XLEN]), 64'h0);
        chk("async_ready", 64'(issue_ready), 64'h1);
        chk("async_err", 64'(sb_err), 64'h0);
        model_reset();
        #1 rst_n = 1'b1;
        step();

        // random traffic, with an occasional asynchronous reset
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 79) == 0) begin
                drive(0, 0, 0, 0, 0, 0, '0, rand_addr(), rand_addr());
                rst_n = 1'b0;
                #1;
                chk("rnd_rst_busy", 64'(rs_busy), 64'h0);
                chk("rnd_rst_ready", 64'(issue_ready), 64'h1);
                model_reset();
                #1 rst_n = 1'b1;
            end
            drive($urandom_range(0, 9) < 6, rand_addr(),
                  $urandom_range(0, 9) < 1, rand_addr(),
                  $urandom_range(0, 9) < 4, rand_addr(), $urandom(),
                  rand_addr(), rand_addr());
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
